// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory req/ack port, the redirect
// input from branch/jump resolution and the valid/ready instruction port
// towards decode.
//   master : instr_fetch side (drives imem_req/addr, instr_valid/instr/instr_pc)
//   slave  : environment side (memory, branch unit, decode)
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads
// over req/ack, buffers returned words with their PC in a DEPTH-entry FIFO
// and presents the head to decode over valid/ready. A redirect flushes the
// FIFO, drops any in-flight word and restarts fetching at the target.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master (memory, redirect and decode ports)
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {WAIT_SPACE, FETCH, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          valid_c;
  logic          pop, push, flush, ack;
  logic [CW-1:0] cnt_nx;
  logic [31:0]   target;

  // A redirect cycle never transfers: the flush wins over any pop.
  assign valid_c         = (cnt_q != '0) && !bus.redirect;
  assign bus.instr_valid = valid_c;
  assign bus.instr       = mem_q[rd_ptr_q].word;
  assign bus.instr_pc    = mem_q[rd_ptr_q].pc;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;

  // Next-state, PC and FIFO update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    flush      = 1'b0;
    pop        = valid_c && bus.instr_ready;
    ack        = req_q && bus.imem_ack;
    target     = bus.redirect_pc & 32'hFFFF_FFFC;
    push       = (state_q == FETCH) && ack && !bus.redirect;
    cnt_nx     = cnt_q + CW'(push) - CW'(pop);

    unique case (state_q)
      WAIT_SPACE: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          state_d    = FETCH;
        end else if (cnt_nx < CW'(DEPTH)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          state_d    = ack ? FETCH : DRAIN;
        end else if (ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (cnt_nx < CW'(DEPTH)) ? FETCH : WAIT_SPACE;
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the stale path; wait for it and drop it.
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          state_d    = ack ? FETCH : DRAIN;
        end else if (ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = WAIT_SPACE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = '{pc: fetch_pc_q, word: bus.imem_rdata};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_nx;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    // DRAIN keeps presenting the abandoned request's address until its ack.
    req_d  = (state_d != WAIT_SPACE);
    addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
  end

  // State and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_SPACE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, all checked
// against a transaction-level reference (expected fetch address, in-flight
// discard flag and a queue of buffered {pc, word} entries).
module tb_instr_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  logic clk;
  logic rst_n;
  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  ent_t        mq[$];
  logic [31:0] exp_pc;
  bit          drain;
  logic [31:0] drain_addr;
  bit          prev_hold;
  logic [31:0] prev_addr;
  bit          prev_room;
  logic [31:0] key;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic model_init();
    mq.delete();
    exp_pc    = RESET_PC;
    drain     = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_room = 1'b1;
  endtask

  // Called once per cycle with inputs settled, before the rising edge.
  task automatic model_step();
    int   sz0;
    bit   exp_v;
    ent_t e;
    sz0 = mq.size();
    // A request is outstanding whenever the buffer had room after last cycle.
    chk("req", {31'b0, bus.imem_req}, {31'b0, prev_room});
    chk("align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
    if (prev_hold) chk("hold_addr", bus.imem_addr, prev_addr);
    exp_v = (sz0 != 0) && !bus.redirect;
    chk("valid", {31'b0, bus.instr_valid}, {31'b0, exp_v});
    if (bus.imem_req && bus.imem_ack) begin
      if (drain) begin
        chk("drain_addr", bus.imem_addr, drain_addr);
        drain = 1'b0;
      end else begin
        chk("fetch_addr", bus.imem_addr, exp_pc);
        if (!bus.redirect) begin
          if (sz0 >= int'(DEPTH)) chk("overflow", 32'(sz0), 32'(DEPTH - 1));
          mq.push_back('{pc: exp_pc, word: bus.imem_rdata});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (exp_v && bus.instr_ready) begin
      e = mq.pop_front();
      chk("instr_pc", bus.instr_pc, e.pc);
      chk("instr", bus.instr, e.word);
    end
    if (bus.redirect) begin
      if (bus.imem_req && !bus.imem_ack && !drain) begin
        drain      = 1'b1;
        drain_addr = bus.imem_addr;
      end
      mq.delete();
      exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end
    prev_hold = bus.imem_req && !bus.imem_ack;
    prev_addr = bus.imem_addr;
    prev_room = mq.size() < int'(DEPTH);
  endtask

  task automatic step(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    bus.imem_ack    = ack;
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_rdata  = mem_word(bus.imem_addr);
    #1;
    model_step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_pc"}, bus.instr_pc, 32'd0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_cycle_req", {31'b0, bus.imem_req}, 32'd0);
    model_init();
  endtask

  initial begin
    key = '0;

    // Free-running memory, data = address, decode always ready
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      chk("free_addr", bus.imem_addr, 32'(i * 4));
    end

    // Downstream stall fills the buffer, one pop reopens fetching at 16
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
    chk("stall_fill", 32'(mq.size()), 32'(DEPTH));
    step(1'b1, 1'b1, 1'b0, '0);
    chk("stall_pop_pc", bus.instr_pc, 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("resume_req", {31'b0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'd16);

    // Redirect while the fetch of address 8 is pending
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("pend_addr0", bus.imem_addr, 32'd8);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("pend_addr1", bus.imem_addr, 32'd8);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("pend_addr2", bus.imem_addr, 32'd8);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("redir_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect together with ack and pop at count 2
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("coinc_valid", {31'b0, bus.instr_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("coinc_valid_n1", {31'b0, bus.instr_valid}, 32'd0);
    chk("coinc_addr", bus.imem_addr, 32'h200);
    chk("coinc_cnt", 32'(mq.size()), 32'd0);

    // Unaligned target and PC wrap-around
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_addr1", bus.imem_addr, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b0, '0);

    // Asynchronous reset with three buffered words
    key = 32'h5A5A_0F0F;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    chk("fill_valid", {31'b0, bus.instr_valid}, 32'd1);
    bus.imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        a, r, d;
      logic [31:0] t;
      key = $urandom;
      a = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 99) < 5);
      t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step(a, r, d, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
